// File: rtl/clock_pkg.sv
// Shared time-of-day widths and limits plus the alarm channel state encoding.
// Pure definitions: no latency, no flow control.
package clock_pkg;
    localparam int MIN_W   = 6;
    localparam int HR_W    = 5;
    localparam int MAX_MIN = 59;
    localparam int MAX_HR  = 23;

    typedef enum logic [1:0] {
        ALM_IDLE,
        ALM_RINGING,
        ALM_SNOOZED
    } alarm_state_t;
endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: target registers, ring/snooze state machine and counters.
// State changes are visible one cycle after their cause; no backpressure, inputs act on sampling.
module alarm_channel
    import clock_pkg::*;
#(
    parameter int RING_MIN   = 5,
    parameter int SNOOZE_MIN = 9,
    parameter int MAX_SNOOZE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_stb,
    input  logic [MIN_W-1:0] wr_minutes,
    input  logic [HR_W-1:0]  wr_hours,
    input  logic             wr_enable,
    input  logic [MIN_W-1:0] curr_minutes,
    input  logic [HR_W-1:0]  curr_hours,
    input  logic             minute_tick,
    input  logic             snooze,
    input  logic             dismiss,
    output logic             ringing,
    output logic             snoozed
);
    localparam logic [5:0] RING_L   = 6'(RING_MIN);
    localparam logic [5:0] SNOOZE_L = 6'(SNOOZE_MIN);
    localparam logic [3:0] MAX_L    = 4'(MAX_SNOOZE);

    alarm_state_t     state;
    logic [MIN_W-1:0] tgt_min;
    logic [HR_W-1:0]  tgt_hr;
    logic             enabled;
    logic [5:0]       ring_cnt;
    logic [3:0]       snooze_cnt;
    logic             match;

    assign match = (curr_minutes == tgt_min) && (curr_hours == tgt_hr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ALM_IDLE;
            tgt_min    <= '0;
            tgt_hr     <= '0;
            enabled    <= 1'b0;
            ring_cnt   <= '0;
            snooze_cnt <= '0;
        end else if (wr_stb) begin
            tgt_min    <= wr_minutes;
            tgt_hr     <= wr_hours;
            enabled    <= wr_enable;
            state      <= ALM_IDLE;
            ring_cnt   <= '0;
            snooze_cnt <= '0;
        end else if (dismiss && state != ALM_IDLE) begin
            state <= ALM_IDLE;
        end else if (snooze && state == ALM_RINGING && snooze_cnt < MAX_L) begin
            state      <= ALM_SNOOZED;
            ring_cnt   <= SNOOZE_L;
            snooze_cnt <= snooze_cnt + 4'd1;
        end else if (minute_tick) begin
            unique case (state)
                ALM_IDLE: begin
                    // Matches are only sampled on a tick, so a held match fires once.
                    if (enabled && match) begin
                        state      <= ALM_RINGING;
                        ring_cnt   <= RING_L;
                        snooze_cnt <= '0;
                    end
                end
                ALM_RINGING: begin
                    ring_cnt <= ring_cnt - 6'd1;
                    if (ring_cnt == 6'd1) state <= ALM_IDLE;
                end
                ALM_SNOOZED: begin
                    if (ring_cnt == 6'd1) begin
                        state    <= ALM_RINGING;
                        ring_cnt <= RING_L;
                    end else begin
                        ring_cnt <= ring_cnt - 6'd1;
                    end
                end
                default: state <= ALM_IDLE;
            endcase
        end
    end

    assign ringing = (state == ALM_RINGING);
    assign snoozed = (state == ALM_SNOOZED);
endmodule

// File: rtl/alarm_bank.sv
// Bank of alarm channels with write validation, set_err pulse, buzzer OR and lowest-ringing index.
// Outputs reflect a cause one cycle later; writes are accepted or rejected immediately, never stalled.
module alarm_bank
    import clock_pkg::*;
#(
    parameter int NUM_ALARMS = 4,
    parameter int RING_MIN   = 5,
    parameter int SNOOZE_MIN = 9,
    parameter int MAX_SNOOZE = 3,
    localparam int IDX_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MIN_W-1:0]      curr_minutes,
    input  logic [HR_W-1:0]       curr_hours,
    input  logic                  minute_tick,
    input  logic                  set_valid,
    input  logic [IDX_W-1:0]      set_idx,
    input  logic [MIN_W-1:0]      set_minutes,
    input  logic [HR_W-1:0]       set_hours,
    input  logic                  set_enable,
    output logic                  set_err,
    input  logic                  snooze,
    input  logic                  dismiss,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic [NUM_ALARMS-1:0] snoozed,
    output logic                  alarm_trigger,
    output logic [IDX_W-1:0]      active_idx
);
    localparam logic [IDX_W:0]   NUM_L   = (IDX_W + 1)'(NUM_ALARMS);
    localparam logic [MIN_W-1:0] MAX_MIN_L = MIN_W'(MAX_MIN);
    localparam logic [HR_W-1:0]  MAX_HR_L  = HR_W'(MAX_HR);

    logic set_ok;

    assign set_ok = set_valid
                 && ({1'b0, set_idx} < NUM_L)
                 && (set_minutes <= MAX_MIN_L)
                 && (set_hours <= MAX_HR_L);

    always_ff @(posedge clk) begin
        if (rst) set_err <= 1'b0;
        else     set_err <= set_valid && !set_ok;
    end

    for (genvar i = 0; i < NUM_ALARMS; i++) begin : g_ch
        localparam logic [IDX_W-1:0] CH = IDX_W'(i);
        logic wr_stb;

        assign wr_stb = set_ok && (set_idx == CH);

        alarm_channel #(
            .RING_MIN   (RING_MIN),
            .SNOOZE_MIN (SNOOZE_MIN),
            .MAX_SNOOZE (MAX_SNOOZE)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .wr_stb       (wr_stb),
            .wr_minutes   (set_minutes),
            .wr_hours     (set_hours),
            .wr_enable    (set_enable),
            .curr_minutes (curr_minutes),
            .curr_hours   (curr_hours),
            .minute_tick  (minute_tick),
            .snooze       (snooze),
            .dismiss      (dismiss),
            .ringing      (ringing[i]),
            .snoozed      (snoozed[i])
        );
    end

    assign alarm_trigger = |ringing;

    // Scan from the top down so the lowest ringing channel is the last to win.
    always_comb begin
        active_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (ringing[i]) active_idx = IDX_W'(i);
        end
    end
endmodule
